// File: rtl/uart_debug_loader.sv
// rtl/uart_debug_loader.sv - UART 8N1 receiver feeding a framed byte loader onto the core debug write port
module uart_debug_loader #(
  parameter int ClksPerBit  = 104,
  parameter int AddrWidth   = 12,
  parameter int TimeoutClks = 1 << 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 debug_o,
  output logic [AddrWidth-1:0] debug_addr_o,
  output logic [7:0]           debug_data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int CntW = $clog2(ClksPerBit);
  localparam logic [CntW-1:0] HalfM1 = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(ClksPerBit - 1);
  localparam int TmoW = $clog2(TimeoutClks + 1);
  localparam logic [TmoW-1:0] TmoM1 = TmoW'(TimeoutClks - 1);
  localparam logic [7:0] SyncByte = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {
    F_IDLE, F_ADDR_L, F_ADDR_H, F_LEN_L, F_LEN_H, F_DATA, F_CSUM
  } frame_state_e;

  // ---------------- RX path ----------------
  logic [1:0]    rx_sync_q, rx_sync_d;
  logic          rx_prev_q, rx_prev_d;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          rx_s;

  assign rx_s      = rx_sync_q[1];
  assign rx_sync_d = {rx_sync_q[0], rx};
  assign rx_prev_d = rx_s;

  always_comb begin
    rx_state_d   = rx_state_q;
    bit_cnt_d    = bit_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          rx_state_d = RX_START;
          bit_cnt_d  = '0;
        end
      end
      RX_START: begin
        // Re-check the start bit at its middle; a high here means a glitch.
        if (bit_cnt_q == HalfM1) begin
          bit_cnt_d  = '0;
          bit_idx_d  = 3'd0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end
      RX_DATA: begin
        if (bit_cnt_q == FullM1) begin
          bit_cnt_d = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
          else                   bit_idx_d  = bit_idx_q + 3'd1;
        end else begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end
      RX_STOP: begin
        if (bit_cnt_q == FullM1) begin
          bit_cnt_d  = '0;
          rx_state_d = RX_IDLE;
          if (rx_s) byte_valid_d = 1'b1;
          else      frame_err_d  = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync_q    <= 2'b11;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      bit_cnt_q    <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_sync_q    <= rx_sync_d;
      rx_prev_q    <= rx_prev_d;
      rx_state_q   <= rx_state_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // ---------------- Frame FSM ----------------
  frame_state_e          state_q, state_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [15:0]           len_q, len_d;
  logic [7:0]            csum_q, csum_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic                  debug_q, debug_d;
  logic [AddrWidth-1:0]  debug_addr_q, debug_addr_d;
  logic [7:0]            debug_data_q, debug_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  abort;
  logic [7:0]            rx_byte;

  assign rx_byte = shift_q;
  assign abort   = (state_q != F_IDLE) &&
                   (frame_err_q || (!byte_valid_q && tmo_q == TmoM1));

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = F_IDLE;
    end else if (byte_valid_q) begin
      case (state_q)
        F_IDLE:   if (rx_byte == SyncByte) state_d = F_ADDR_L;
        F_ADDR_L: state_d = F_ADDR_H;
        F_ADDR_H: state_d = F_LEN_L;
        F_LEN_L:  state_d = F_LEN_H;
        F_LEN_H:  state_d = ({rx_byte, len_q[7:0]} == 16'd0) ? F_CSUM : F_DATA;
        F_DATA:   if (len_q == 16'd1) state_d = F_CSUM;
        F_CSUM:   state_d = F_IDLE;
        default:  state_d = F_IDLE;
      endcase
    end
  end

  always_comb begin
    addr_d       = addr_q;
    len_d        = len_q;
    csum_d       = csum_q;
    debug_d      = 1'b0;
    debug_addr_d = debug_addr_q;
    debug_data_d = debug_data_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    tmo_d        = (state_q == F_IDLE || byte_valid_q || abort) ? '0 : tmo_q + TmoW'(1);
    if (abort) begin
      err_d  = 1'b1;
      busy_d = 1'b0;
    end else if (byte_valid_q) begin
      case (state_q)
        F_IDLE: begin
          if (rx_byte == SyncByte) begin
            busy_d = 1'b1;
            err_d  = 1'b0;
            csum_d = 8'h00;
          end
        end
        F_ADDR_L: begin
          addr_d[7:0] = rx_byte;
          csum_d      = csum_q ^ rx_byte;
        end
        F_ADDR_H: begin
          // Address bits above AddrWidth are dropped by the truncating cast.
          addr_d = AddrWidth'({rx_byte, addr_q[7:0]});
          csum_d = csum_q ^ rx_byte;
        end
        F_LEN_L: begin
          len_d  = {len_q[15:8], rx_byte};
          csum_d = csum_q ^ rx_byte;
        end
        F_LEN_H: begin
          len_d  = {rx_byte, len_q[7:0]};
          csum_d = csum_q ^ rx_byte;
        end
        F_DATA: begin
          debug_d      = 1'b1;
          debug_addr_d = addr_q;
          debug_data_d = rx_byte;
          addr_d       = addr_q + AddrWidth'(1);
          len_d        = len_q - 16'd1;
          csum_d       = csum_q ^ rx_byte;
        end
        F_CSUM: begin
          busy_d = 1'b0;
          if (rx_byte == csum_q) done_d = 1'b1;
          else                   err_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= F_IDLE;
      addr_q       <= '0;
      len_q        <= 16'd0;
      csum_q       <= 8'h00;
      tmo_q        <= '0;
      debug_q      <= 1'b0;
      debug_addr_q <= '0;
      debug_data_q <= 8'h00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      csum_q       <= csum_d;
      tmo_q        <= tmo_d;
      debug_q      <= debug_d;
      debug_addr_q <= debug_addr_d;
      debug_data_q <= debug_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign debug_o      = debug_q;
  assign debug_addr_o = debug_addr_q;
  assign debug_data_o = debug_data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
